// File: rtl/spi_peripheral.sv
// SPI target (mode 0, MSB first) fully in the clk domain; full-duplex word exchange with a
// one-entry TX buffer. Optional status flags are enabled by defining SPI_PERIPH_STATUS_EN.
module spi_peripheral #(
  parameter int unsigned         DATA_W      = 8,
  parameter int unsigned         SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0]   IDLE_WORD   = DATA_W'('hFF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_clk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy
`ifdef SPI_PERIPH_STATUS_EN
  ,
  output logic              rx_overrun,
  output logic              tx_underrun,
  input  logic              status_clr
`endif
);

  localparam int unsigned CNT_W   = $clog2(DATA_W);
  localparam int unsigned LAST_IX = DATA_W - 1;

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t               state;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                 sclk_q;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 reload;
  logic [DATA_W-1:0]    tx_shift;
  logic [DATA_W-1:0]    rx_shift;
  logic [DATA_W-1:0]    buf_data;

  logic                 sclk_s;
  logic                 cs_s;
  logic                 mosi_s;
  logic                 sclk_rise;
  logic                 sclk_fall;
  logic                 load_c;
  logic [DATA_W-1:0]    load_word;
  logic [DATA_W-1:0]    rx_next;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign rx_next   = {rx_shift[DATA_W-2:0], mosi_s};

  // A load happens on selection and on the first falling edge after a completed word.
  assign load_c    = ((state == ST_IDLE) && !cs_s) ||
                     ((state == ST_SHIFT) && !cs_s && sclk_fall && reload);
  assign load_word = tx_ready ? IDLE_WORD : buf_data;

  // Input synchronisers and previous-cycle copy of the clock for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_q    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_q    <= sclk_s;
    end
  end

  // One-entry TX buffer; tx_ready doubles as the buffer-empty flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_ready <= 1'b1;
      buf_data <= '0;
    end else if (load_c && !tx_ready) begin
      tx_ready <= 1'b1;
    end else if (tx_valid && tx_ready) begin
      buf_data <= tx_data;
      tx_ready <= 1'b0;
    end
  end

  // Frame FSM with shift registers and registered pin/strobe outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      miso     <= 1'b0;
      miso_oe  <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
      bit_cnt  <= '0;
      reload   <= 1'b0;
      tx_shift <= '0;
      rx_shift <= '0;
    end else begin
      rx_valid <= 1'b0;
      busy     <= ~cs_s;
      case (state)
        ST_IDLE: begin
          if (!cs_s) begin
            state    <= ST_SHIFT;
            tx_shift <= load_word;
            miso     <= load_word[DATA_W-1];
            miso_oe  <= 1'b1;
            bit_cnt  <= '0;
            reload   <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (cs_s) begin
            // Deselect wins over any same-cycle clock edge; partial word is dropped.
            state    <= ST_IDLE;
            miso     <= 1'b0;
            miso_oe  <= 1'b0;
            bit_cnt  <= '0;
            reload   <= 1'b0;
            rx_shift <= '0;
          end else begin
            if (sclk_rise) begin
              rx_shift <= rx_next;
              if (bit_cnt == CNT_W'(LAST_IX)) begin
                rx_data  <= rx_next;
                rx_valid <= 1'b1;
                bit_cnt  <= '0;
                reload   <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
            if (sclk_fall) begin
              if (reload) begin
                tx_shift <= load_word;
                miso     <= load_word[DATA_W-1];
                reload   <= 1'b0;
              end else begin
                tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                miso     <= tx_shift[DATA_W-2];
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SPI_PERIPH_STATUS_EN
  logic rx_unread;

  // Sticky link-health flags; a status_clr pulse marks the current word as read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
      rx_unread   <= 1'b0;
    end else begin
      if (rx_valid && rx_unread) rx_overrun <= 1'b1;
      if (load_c && tx_ready) tx_underrun <= 1'b1;
      if (rx_valid) begin
        rx_unread <= 1'b1;
      end else if (status_clr) begin
        rx_unread <= 1'b0;
      end
      if (status_clr) begin
        rx_overrun  <= 1'b0;
        tx_underrun <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_spi_peripheral.sv
// Bench for spi_peripheral: drives a mode-0 controller against an 8-bit and a 16-bit instance and
// compares MISO words, received words and handshake flags with a word-level reference model.
module tb_spi_peripheral;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        spi_clk;
  logic        mosi;
  logic        cs_n8;
  logic        cs_n16;
  logic [15:0] tx_data;
  logic        tx_valid8;
  logic        tx_valid16;

  logic        miso8, miso_oe8, tx_ready8, rx_valid8, busy8;
  logic [7:0]  rx_data8;
  logic        miso16, miso_oe16, tx_ready16, rx_valid16, busy16;
  logic [15:0] rx_data16;
`ifdef SPI_PERIPH_STATUS_EN
  logic        status_clr;
  logic        rx_overrun8, tx_underrun8, rx_overrun16, tx_underrun16;
`endif

  spi_peripheral #(.DATA_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .cs_n(cs_n8), .mosi(mosi),
    .miso(miso8), .miso_oe(miso_oe8), .tx_data(tx_data[7:0]), .tx_valid(tx_valid8),
    .tx_ready(tx_ready8), .rx_data(rx_data8), .rx_valid(rx_valid8), .busy(busy8)
`ifdef SPI_PERIPH_STATUS_EN
    , .rx_overrun(rx_overrun8), .tx_underrun(tx_underrun8), .status_clr(status_clr)
`endif
  );

  spi_peripheral #(.DATA_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .cs_n(cs_n16), .mosi(mosi),
    .miso(miso16), .miso_oe(miso_oe16), .tx_data(tx_data), .tx_valid(tx_valid16),
    .tx_ready(tx_ready16), .rx_data(rx_data16), .rx_valid(rx_valid16), .busy(busy16)
`ifdef SPI_PERIPH_STATUS_EN
    , .rx_overrun(rx_overrun16), .tx_underrun(tx_underrun16), .status_clr(status_clr)
`endif
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit sel16 = 1'b0;
  int w = 8;

  // Reference model: one buffer slot per instance, plus per-frame word tables.
  logic        model_full [2];
  logic [15:0] model_buf  [2];
  logic [15:0] mosi_w [8];
  bit          push_en[8];
  logic [15:0] push_w [8];
  logic [15:0] got    [8];
  logic [15:0] exp_m  [9];
  logic [15:0] rxq8[$];
  logic [15:0] rxq16[$];

  always @(negedge clk) begin
    if (rx_valid8) rxq8.push_back(16'(rx_data8));
    if (rx_valid16) rxq16.push_back(16'(rx_data16));
  end

  function automatic logic cur_miso();     return sel16 ? miso16 : miso8;         endfunction
  function automatic logic cur_oe();       return sel16 ? miso_oe16 : miso_oe8;   endfunction
  function automatic logic cur_busy();     return sel16 ? busy16 : busy8;         endfunction
  function automatic logic cur_tx_ready(); return sel16 ? tx_ready16 : tx_ready8; endfunction
  function automatic int   cur_sel();      return sel16 ? 1 : 0;                  endfunction

  task automatic set_cs(input logic v);
    if (sel16) cs_n16 = v; else cs_n8 = v;
  endtask

  task automatic set_valid(input logic v);
    if (sel16) tx_valid16 = v; else tx_valid8 = v;
  endtask

  // Every load takes the buffered word if present, otherwise the idle word 'hFF.
  task automatic model_load(output logic [15:0] word);
    int s = cur_sel();
    word = model_full[s] ? model_buf[s] : 16'h00FF;
    model_full[s] = 1'b0;
  endtask

  task automatic push_idle(input logic [15:0] d);
    int s = cur_sel();
    checks++;
    if (cur_tx_ready() !== ~model_full[s]) begin
      errors++;
      $display("FAIL push_ready: got %b want %b", cur_tx_ready(), ~model_full[s]);
    end
    if (!model_full[s]) begin
      tx_data = d;
      @(negedge clk);
      set_valid(1'b1);
      @(negedge clk);
      set_valid(1'b0);
      model_full[s] = 1'b1;
      model_buf[s]  = d;
    end
  endtask

  // One chip-select frame; abort_bits>0 deselects after that many bits.
  task automatic run_frame(input int nwords, input int half, input int abort_bits);
    int total, nfull, k, b, s;
    logic [15:0] word;
    logic [15:0] rx;
    s = cur_sel();
    total = (abort_bits > 0) ? abort_bits : nwords * w;
    nfull = total / w;
    for (int i = 0; i < 8; i++) got[i] = 16'h0;
    rxq8.delete();
    rxq16.delete();
    model_load(word);
    exp_m[0] = word;
    @(negedge clk);
    set_cs(1'b0);
    for (int j = 0; j < total; j++) begin
      k = j / w;
      b = w - 1 - (j % w);
      mosi = mosi_w[k][b];
      if (b == w - 3 && push_en[k]) begin
        checks++;
        if (cur_tx_ready() !== 1'b1) begin
          errors++;
          $display("FAIL mid_tx_ready word %0d: got %b want 1", k, cur_tx_ready());
        end
        tx_data = push_w[k];
        set_valid(1'b1);
        model_full[s] = 1'b1;
        model_buf[s]  = push_w[k];
      end
      for (int c = 0; c < half; c++) begin
        if (c == 1) set_valid(1'b0);
        @(negedge clk);
      end
      spi_clk = 1'b1;
      for (int c = 0; c < half; c++) @(negedge clk);
      got[k][b] = cur_miso();
      if (j == 0) begin
        checks++;
        if (cur_oe() !== 1'b1 || cur_busy() !== 1'b1) begin
          errors++;
          $display("FAIL selected_flags: oe %b busy %b want 1 1", cur_oe(), cur_busy());
        end
        checks++;
        if (cur_tx_ready() !== ~model_full[s]) begin
          errors++;
          $display("FAIL ready_after_load: got %b want %b", cur_tx_ready(), ~model_full[s]);
        end
      end
      spi_clk = 1'b0;
      if (b == 0) begin
        model_load(word);
        exp_m[k+1] = word;
      end
    end
    mosi = 1'b0;
    for (int c = 0; c < half; c++) @(negedge clk);
    set_cs(1'b1);
    repeat (8) @(negedge clk);
    checks++;
    if (cur_oe() !== 1'b0 || cur_miso() !== 1'b0 || cur_busy() !== 1'b0) begin
      errors++;
      $display("FAIL deselected: oe %b miso %b busy %b want 0 0 0", cur_oe(), cur_miso(), cur_busy());
    end
    for (int i = 0; i < nfull; i++) begin
      checks++;
      if (got[i] !== exp_m[i]) begin
        errors++;
        $display("FAIL miso_word %0d: got %h want %h", i, got[i], exp_m[i]);
      end
    end
    checks++;
    if ((sel16 ? rxq16.size() : rxq8.size()) != nfull) begin
      errors++;
      $display("FAIL rx_count: got %0d want %0d", sel16 ? rxq16.size() : rxq8.size(), nfull);
    end else begin
      for (int i = 0; i < nfull; i++) begin
        rx = sel16 ? rxq16[i] : rxq8[i];
        checks++;
        if (rx !== mosi_w[i]) begin
          errors++;
          $display("FAIL rx_word %0d: got %h want %h", i, rx, mosi_w[i]);
        end
      end
    end
  endtask

  task automatic clear_plan();
    for (int i = 0; i < 8; i++) begin
      push_en[i] = 1'b0;
      push_w[i]  = 16'h0;
      mosi_w[i]  = 16'h0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    spi_clk = 1'b0; mosi = 1'b0; cs_n8 = 1'b1; cs_n16 = 1'b1;
    tx_data = 16'h0; tx_valid8 = 1'b0; tx_valid16 = 1'b0;
`ifdef SPI_PERIPH_STATUS_EN
    status_clr = 1'b0;
`endif
    model_full[0] = 1'b0; model_full[1] = 1'b0;
    model_buf[0] = 16'h0; model_buf[1] = 16'h0;
    repeat (3) @(negedge clk);
    checks++;
    if ({miso8, miso_oe8, tx_ready8, rx_valid8, busy8} !== 5'b00100 || rx_data8 !== 8'h00) begin
      errors++;
      $display("FAIL reset8: miso %b oe %b rdy %b rxv %b busy %b rx %h want 0 0 1 0 0 00",
               miso8, miso_oe8, tx_ready8, rx_valid8, busy8, rx_data8);
    end
    checks++;
    if (tx_ready16 !== 1'b1 || rx_data16 !== 16'h0 || miso_oe16 !== 1'b0) begin
      errors++;
      $display("FAIL reset16: rdy %b rx %h oe %b want 1 0000 0", tx_ready16, rx_data16, miso_oe16);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single();
    sel16 = 1'b0; w = 8; clear_plan();
    push_idle(16'h00A5);
    mosi_w[0] = 16'h003C;
    run_frame(1, 4, 0);
  endtask

  task automatic test_back_to_back();
    sel16 = 1'b0; w = 8; clear_plan();
    push_idle(16'h0001);
    push_en[0] = 1'b1; push_w[0] = 16'h0002;
    mosi_w[0] = 16'h00C3; mosi_w[1] = 16'h005A;
    run_frame(2, 4, 0);
  endtask

  task automatic test_underrun();
    sel16 = 1'b0; w = 8; clear_plan();
`ifdef SPI_PERIPH_STATUS_EN
    @(negedge clk) status_clr = 1'b1;
    @(negedge clk) status_clr = 1'b0;
`endif
    mosi_w[0] = 16'h0000;
    run_frame(1, 4, 0);
`ifdef SPI_PERIPH_STATUS_EN
    checks++;
    if (tx_underrun8 !== 1'b1) begin
      errors++;
      $display("FAIL underrun_flag: got %b want 1", tx_underrun8);
    end
    @(negedge clk) status_clr = 1'b1;
    @(negedge clk) status_clr = 1'b0;
    checks++;
    if (tx_underrun8 !== 1'b0) begin
      errors++;
      $display("FAIL underrun_clear: got %b want 0", tx_underrun8);
    end
`endif
  endtask

  task automatic test_abort();
    sel16 = 1'b0; w = 8; clear_plan();
    push_idle(16'($urandom_range(0, 255)));
    mosi_w[0] = 16'($urandom_range(0, 255));
    run_frame(1, 4, 5);
    clear_plan();
    push_idle(16'($urandom_range(0, 255)));
    mosi_w[0] = 16'($urandom_range(0, 255));
    run_frame(1, 4, 0);
  endtask

  task automatic test_reset_mid();
    sel16 = 1'b0; w = 8; clear_plan();
    push_idle(16'h0077);
    @(negedge clk) cs_n8 = 1'b0;
    repeat (6) @(negedge clk);
    tx_data = 16'h0099;
    tx_valid8 = 1'b1;
    @(negedge clk) tx_valid8 = 1'b0;
    mosi = 1'b1;
    repeat (4) @(negedge clk) spi_clk = ~spi_clk;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({miso8, miso_oe8, tx_ready8, rx_valid8, busy8} !== 5'b00100 || rx_data8 !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid: miso %b oe %b rdy %b rxv %b busy %b rx %h want 0 0 1 0 0 00",
               miso8, miso_oe8, tx_ready8, rx_valid8, busy8, rx_data8);
    end
    cs_n8 = 1'b1; spi_clk = 1'b0; mosi = 1'b0;
    model_full[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (tx_ready8 !== 1'b1 || miso_oe8 !== 1'b0) begin
      errors++;
      $display("FAIL after_reset: rdy %b oe %b want 1 0", tx_ready8, miso_oe8);
    end
    clear_plan();
    push_idle(16'($urandom_range(0, 255)));
    mosi_w[0] = 16'($urandom_range(0, 255));
    run_frame(1, 4, 0);
  endtask

  task automatic test_min_ratio();
    int nw;
    sel16 = 1'b1; w = 16;
    for (int f = 0; f < 100; f++) begin
      clear_plan();
      nw = int'($urandom_range(1, 3));
      for (int k = 0; k < nw; k++) begin
        mosi_w[k]  = 16'($urandom);
        push_en[k] = 1'($urandom_range(0, 1));
        push_w[k]  = 16'($urandom);
      end
      if ($urandom_range(0, 1) == 1) push_idle(16'($urandom));
      run_frame(nw, 2, 0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_reset_mid();
    test_min_ratio();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
